// File: rtl/imm_ext_pkg.sv
// Shared types and default widths for the immediate extender pipeline.
package imm_ext_pkg;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SIGN   = 2'd0,
        ZERO   = 2'd1,
        UPPER  = 2'd2,
        BRANCH = 2'd3
    } ext_mode_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: widens an IN_W immediate to OUT_W bits
// as sign, zero, upper (LUI) or branch offset (sign-extended, times four).
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [IN_W-1:0]  data,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] result
);

    localparam int EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sign_ext;

    assign sign_ext = {{EXT_W{data[IN_W-1]}}, data};

    always_comb begin
        result = sign_ext;
        case (mode)
            SIGN:    result = sign_ext;
            ZERO:    result = {{EXT_W{1'b0}}, data};
            UPPER:   result = {data, {EXT_W{1'b0}}};
            BRANCH:  result = {sign_ext[OUT_W-3:0], 2'b00};
            default: result = sign_ext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a two-entry skid buffer between decode
// and the ID/EX boundary; in_ready_o is decoded purely from the state register.
//
// state | meaning
// EMPTY | no result held, out_valid_o low
// ONE   | result in main, skid free
// TWO   | main and skid both hold results, input stalled
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] data_o
);

    skid_state_t      state_q, state_d;
    logic [OUT_W-1:0] main_q, skid_q;
    logic [OUT_W-1:0] ext_result;
    logic             in_xfer, out_xfer;
    logic             load_main_new, load_main_skid, load_skid_new;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .data   (data_i),
        .mode   (mode_i),
        .result (ext_result)
    );

    assign in_ready_o  = (state_q != TWO);
    assign out_valid_o = (state_q != EMPTY);
    assign data_o      = main_q;

    assign in_xfer  = in_valid_i  && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;

    always_comb begin
        state_d        = state_q;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid_new  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_main_new = 1'b1;
                    state_d       = ONE;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    load_skid_new = 1'b1;
                    state_d       = TWO;
                end else if (in_xfer && out_xfer) begin
                    load_main_new = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // Skid always holds the younger result, so it moves up on drain.
                if (out_xfer) begin
                    load_main_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_new) begin
                main_q <= ext_result;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_new) begin
                skid_q <= ext_result;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed vectors plus random traffic checked
// against a two-deep FIFO reference model and an arithmetic extension model.
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] data_in   = '0;
    logic [1:0]  mode_in   = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_out;

    logic        rst8      = 1'b1;
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  data8     = '0;
    logic [1:0]  mode8     = 2'd0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [15:0] dout8;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (data_in),
        .mode_i      (mode_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data_out)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16)) u_dut8 (
        .clk_i       (clk),
        .rst_i       (rst8),
        .in_valid_i  (in_valid8),
        .in_ready_o  (in_ready8),
        .data_i      (data8),
        .mode_i      (mode8),
        .out_valid_o (out_valid8),
        .out_ready_i (out_ready8),
        .data_o      (dout8)
    );

    int     checks = 0;
    int     errors = 0;
    longint model_q[$];

    // Extension computed arithmetically: signed value, times four, masked to width.
    function automatic longint ext_ref(int in_w, int out_w, longint d, int m);
        longint mask, sval;
        mask = (longint'(1) << out_w) - 1;
        sval = (((d >> (in_w - 1)) & 1) != 0) ? d - (longint'(1) << in_w) : d;
        case (m)
            0:       return sval & mask;
            1:       return d;
            2:       return (d << (out_w - in_w)) & mask;
            default: return (sval * 4) & mask;
        endcase
    endfunction

    // Called at a negedge: drive inputs, cross one rising edge, update the
    // FIFO model, and return at the following negedge.
    task automatic tick(input logic v, input logic [15:0] d, input logic [1:0] m,
                        input logic ordy, input logic r);
        bit     ix, ox;
        longint res;
        in_valid  = v;
        data_in   = d;
        mode_in   = m;
        out_ready = ordy;
        rst       = r;
        ix  = v && model_q.size() < 2;
        ox  = ordy && model_q.size() > 0;
        res = ext_ref(16, 32, longint'(d), int'(m));
        @(posedge clk);
        if (r) begin
            model_q.delete();
        end else begin
            if (ox) void'(model_q.pop_front());
            if (ix) model_q.push_back(res);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, 16'h0000, SIGN, 1'b0, 1'b1);
        tick(1'b1, 16'h1234, ZERO, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", data_out); end
    endtask

    task automatic test_sign_zero();
        logic [15:0] dv[3];
        logic [1:0]  mv[3];
        logic [31:0] ev[3];
        dv = '{16'h8000, 16'h8000, 16'h7FFF};
        mv = '{SIGN, ZERO, SIGN};
        ev = '{32'hFFFF8000, 32'h00008000, 32'h00007FFF};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, dv[i], mv[i], 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL sign_zero_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++;
            if (data_out !== ev[i]) begin errors++; $display("FAIL sign_zero_data[%0d]: got %h expected %h", i, data_out, ev[i]); end
            tick(1'b0, 16'h0000, SIGN, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL sign_zero_drain[%0d]: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_upper_branch();
        logic [15:0] dv[3];
        logic [1:0]  mv[3];
        logic [31:0] ev[3];
        dv = '{16'h1234, 16'hFFFF, 16'h4000};
        mv = '{UPPER, BRANCH, BRANCH};
        ev = '{32'h12340000, 32'hFFFFFFFC, 32'h00010000};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, dv[i], mv[i], 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || data_out !== ev[i]) begin
                errors++;
                $display("FAIL upper_branch[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, data_out, ev[i]);
            end
            tick(1'b0, 16'h0000, SIGN, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] got[$];
        bit          c_sent, acc;
        tick(1'b1, 16'h0001, SIGN, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b1 || data_out !== 32'h1) begin
            errors++;
            $display("FAIL bp_first: got ready=%b data=%h expected ready=1 data=00000001", in_ready, data_out);
        end
        tick(1'b1, 16'h0002, SIGN, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got ready=%b expected 0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 16'h0003, SIGN, 1'b0, 1'b0);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== 32'h1) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got ready=%b valid=%b data=%h expected ready=0 valid=1 data=00000001",
                         k, in_ready, out_valid, data_out);
            end
        end
        c_sent = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) got.push_back(data_out);
            if (k == 1) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_ready: got %b expected 1", in_ready); end
            end
            acc = !c_sent && in_ready;
            tick(!c_sent, 16'h0003, SIGN, 1'b1, 1'b0);
            if (acc) c_sent = 1'b1;
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs expected 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got[k] !== 32'(k + 1)) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h expected %h", k, got[k], 32'(k + 1));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [1:0]  m;
        logic [31:0] exp_v;
        int          bubbles = 0;
        for (int i = 0; i < 8; i++) begin
            d     = 16'($urandom);
            m     = 2'($urandom_range(0, 3));
            exp_v = 32'(ext_ref(16, 32, longint'(d), int'(m)));
            tick(1'b1, d, m, 1'b1, 1'b0);
            if (out_valid !== 1'b1 || in_ready !== 1'b1) bubbles++;
            checks++;
            if (data_out !== exp_v) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %h expected %h (d=%h mode=%0d)", i, data_out, exp_v, d, m);
            end
        end
        checks++;
        if (bubbles != 0) begin errors++; $display("FAIL b2b_bubbles: got %0d expected 0", bubbles); end
        tick(1'b0, 16'h0000, SIGN, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_in_two();
        tick(1'b1, 16'h00AA, ZERO, 1'b0, 1'b0);
        tick(1'b1, 16'h00BB, ZERO, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst2_full: got ready=%b expected 0", in_ready); end
        tick(1'b1, 16'h5555, SIGN, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 32'h0) begin
            errors++;
            $display("FAIL rst2_clear: got valid=%b ready=%b data=%h expected valid=0 ready=1 data=00000000",
                     out_valid, in_ready, data_out);
        end
        tick(1'b1, 16'h8000, SIGN, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 32'hFFFF8000) begin
            errors++;
            $display("FAIL rst2_next: got valid=%b data=%h expected valid=1 data=ffff8000", out_valid, data_out);
        end
        tick(1'b0, 16'h0000, SIGN, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2) ||
                (model_q.size() > 0 && data_out !== 32'(model_q[0]))) begin
                errors++;
                if (bad < 5) begin
                    $display("FAIL random[%0d]: got valid=%b ready=%b data=%h expected depth=%0d head=%h",
                             i, out_valid, in_ready, data_out, model_q.size(),
                             (model_q.size() > 0) ? 32'(model_q[0]) : 32'h0);
                end
                bad++;
            end
            tick(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
        end
    endtask

    task automatic test_param_sweep();
        logic [7:0]  dv[3];
        logic [1:0]  mv[3];
        logic [15:0] ev[3];
        dv = '{8'h80, 8'h12, 8'hFF};
        mv = '{SIGN, UPPER, BRANCH};
        ev = '{16'hFF80, 16'h1200, 16'hFFFC};
        rst8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || dout8 !== 16'h0) begin
            errors++;
            $display("FAIL p8_reset: got valid=%b ready=%b data=%h expected valid=0 ready=1 data=0000",
                     out_valid8, in_ready8, dout8);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid8  = 1'b1;
            data8      = dv[i];
            mode8      = mv[i];
            out_ready8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid8 = 1'b0;
            checks++;
            if (out_valid8 !== 1'b1 || dout8 !== ev[i]) begin
                errors++;
                $display("FAIL p8_data[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, out_valid8, dout8, ev[i]);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sign_zero();
        test_upper_branch();
        test_back_pressure();
        test_back_to_back();
        test_reset_in_two();
        test_random();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
